// File: rtl/selftrigger_movmean_channel_param_if.sv
// Channel-side bus of one self-trigger channel: control/sample inputs and monitor/trigger outputs.
// Handshake: no valid/ready; x is taken every clk, thr_load/count_clr are 1-cycle strobes, trigger_output is a 1-cycle strobe.
interface selftrigger_movmean_channel_param_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic                     enable;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] baseline;
  logic signed [31:0]       threshold_value;
  logic        [DATA_W-1:0] hysteresis;
  logic                     thr_load;
  logic        [1:0]        output_sel;
  logic                     trigger_ch_enable;
  logic                     count_clr;
  logic                     trigger_output;
  logic signed [DATA_W-1:0] y;
  logic        [CNT_W-1:0]  trig_count;
  logic                     busy;
  logic        [1:0]        fsm_state;

  modport master (
    output enable, x, baseline, threshold_value, hysteresis, thr_load,
           output_sel, trigger_ch_enable, count_clr,
    input  trigger_output, y, trig_count, busy, fsm_state
  );

  modport slave (
    input  enable, x, baseline, threshold_value, hysteresis, thr_load,
           output_sel, trigger_ch_enable, count_clr,
    output trigger_output, y, trig_count, busy, fsm_state
  );
endinterface

// File: rtl/selftrigger_movmean_channel_param.sv
// Per-channel self-trigger: baseline subtraction, power-of-two moving average,
// threshold FSM with polarity, hysteresis and hold-off, saturating trigger counter.
module selftrigger_movmean_channel_param #(
  parameter int DATA_W    = 16,
  parameter int AVG_LOG2  = 5,
  parameter int HOLDOFF   = 256,
  parameter int CNT_W     = 16,
  parameter int POLARITY  = 1,
  parameter int THR_RESET = 99999
) (
  input logic clk,
  input logic reset,
  selftrigger_movmean_channel_param_if.slave bus
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int HW    = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TRIG = 2'd1, HOLDOFF_ST = 2'd2, REARM = 2'd3} state_t;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    if (v[DATA_W] == v[DATA_W-1]) return v[DATA_W-1:0];
    else if (v[DATA_W])           return {1'b1, {(DATA_W-1){1'b0}}};
    else                          return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  logic signed [DATA_W-1:0] d, d_d1, x_d1, x_d2, b_d1, b_d2, y_q, y_next;
  logic signed [DATA_W-1:0] dline [DEPTH];
  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic signed [DATA_W-1:0] mean_w;
  logic signed [DATA_W:0]   diff_w, s_w, s_q, mb_sum, mean_x;
  logic signed [31:0]       thr_q;
  logic        [DATA_W-1:0] hyst_q;
  logic signed [32:0]       s_ext, thr_ext, hyst_ext, rearm_lvl;
  logic        [HW-1:0]     hold_cnt;
  logic        [CNT_W-1:0]  trig_count_q;
  logic                     trig_q, busy_q, fire;
  state_t                   state, state_next;

  assign diff_w = {bus.x[DATA_W-1], bus.x} - {bus.baseline[DATA_W-1], bus.baseline};
  assign acc_sh = acc >>> AVG_LOG2;
  assign mean_w = acc_sh[DATA_W-1:0];
  assign mean_x = {mean_w[DATA_W-1], mean_w};
  assign s_w    = (POLARITY != 0) ? (~mean_x + 1'b1) : mean_x;
  assign mb_sum = mean_x + {b_d2[DATA_W-1], b_d2};

  // Raw x and baseline always shift so the bypass path keeps running while the filter is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_d1 <= '0;
      x_d2 <= '0;
      b_d1 <= '0;
      b_d2 <= '0;
    end else begin
      x_d1 <= bus.x;
      x_d2 <= x_d1;
      b_d1 <= bus.baseline;
      b_d2 <= b_d1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d    <= '0;
      d_d1 <= '0;
      acc  <= '0;
      s_q  <= '0;
      for (int i = 0; i < DEPTH; i++) dline[i] <= '0;
    end else if (bus.enable) begin
      d    <= sat(diff_w);
      d_d1 <= d;
      acc  <= acc + {{AVG_LOG2{d[DATA_W-1]}}, d}
                  - {{AVG_LOG2{dline[DEPTH-1][DATA_W-1]}}, dline[DEPTH-1]};
      dline[0] <= d;
      for (int i = 1; i < DEPTH; i++) dline[i] <= dline[i-1];
      s_q  <= s_w;
    end
  end

  always_comb begin
    y_next = x_d2;
    if (bus.enable) begin
      case (bus.output_sel)
        2'b00:   y_next = sat(mb_sum);
        2'b01:   y_next = d_d1;
        2'b10:   y_next = x_d2;
        default: y_next = sat(s_w);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q    <= '0;
      thr_q  <= THR_RESET;
      hyst_q <= '0;
    end else begin
      y_q <= y_next;
      if (bus.thr_load) begin
        thr_q  <= bus.threshold_value;
        hyst_q <= bus.hysteresis;
      end
    end
  end

  assign s_ext     = 33'(s_q);
  assign thr_ext   = 33'(thr_q);
  assign hyst_ext  = 33'(hyst_q);
  assign rearm_lvl = thr_ext - hyst_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (s_ext > thr_ext) state_next = TRIG;
      TRIG:       state_next = HOLDOFF_ST;
      HOLDOFF_ST: if (hold_cnt == '0) state_next = REARM;
      REARM:      if (s_ext < rearm_lvl) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (!bus.enable) state_next = IDLE;
  end

  assign fire = (state_next == TRIG);

  // Strobe, counter and busy are registered alongside the state so they line up with TRIG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt     <= '0;
      trig_count_q <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (!bus.enable)                                hold_cnt <= '0;
      else if (state == TRIG)                         hold_cnt <= HW'(HOLDOFF - 1);
      else if (state == HOLDOFF_ST && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      if (fire)
        trig_count_q <= bus.count_clr ? CNT_W'(1)
                      : ((&trig_count_q) ? trig_count_q : trig_count_q + 1'b1);
      else if (bus.count_clr)
        trig_count_q <= '0;

      trig_q <= fire & bus.trigger_ch_enable;
      busy_q <= (state_next != IDLE);
    end
  end

  assign bus.y              = y_q;
  assign bus.trigger_output = trig_q;
  assign bus.trig_count     = trig_count_q;
  assign bus.busy           = busy_q;
  assign bus.fsm_state      = state;
endmodule

// File: tb/tb_selftrigger_movmean_channel_param.sv
// Directed bench for one self-trigger channel (AVG_LOG2=5, HOLDOFF=8, CNT_W=4, negative polarity).
module tb_selftrigger_movmean_channel_param;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int HOLDOFF = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;

  selftrigger_movmean_channel_param_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  selftrigger_movmean_channel_param #(
    .DATA_W(DATA_W), .AVG_LOG2(5), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W),
    .POLARITY(1), .THR_RESET(99999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.trigger_output === 1'b1) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.x = '0;
    bus.baseline = '0;
    bus.threshold_value = '0;
    bus.hysteresis = '0;
    bus.thr_load = 1'b0;
    bus.output_sel = 2'b01;
    bus.trigger_ch_enable = 1'b1;
    bus.count_clr = 1'b0;
    reset = 1'b1;
    tick(2);
    check("rst_y", bus.y, 0);
    check("rst_count", bus.trig_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.fsm_state, 0);
    reset = 1'b0;

    // x - baseline path and raw/polarity selections
    bus.baseline = 1000; bus.x = 1000; tick(40);
    check("d_flat", bus.y, 0);
    bus.x = 1320; tick(2);
    check("d_before", bus.y, 0);
    tick(1);
    check("d_step", bus.y, 320);
    bus.output_sel = 2'b10; tick(1);
    check("raw_x", bus.y, 1320);
    tick(40);
    bus.output_sel = 2'b11; tick(1);
    check("pol_mean", bus.y, -320);

    // mean + baseline ramp
    bus.x = 1000; tick(40);
    bus.output_sel = 2'b00; tick(1);
    check("mb_flat", bus.y, 1000);
    bus.x = 1320; tick(3);
    check("mb_c3", bus.y, 1010);
    tick(1);
    check("mb_c4", bus.y, 1020);
    tick(29);
    check("mb_c33", bus.y, 1310);
    tick(1);
    check("mb_c34", bus.y, 1320);
    tick(5);
    check("mb_hold", bus.y, 1320);

    // async reset mid-stream
    #1 reset = 1'b1;
    #1;
    check("arst_y", bus.y, 0);
    check("arst_count", bus.trig_count, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_trig", bus.trigger_output, 0);
    tick(1);
    reset = 1'b0;

    // reset threshold is above any reachable s
    bus.baseline = 8000; bus.x = 0; tick(40);
    check("thr_rst_count", bus.trig_count, 0);
    check("thr_rst_state", bus.fsm_state, 0);

    bus.x = 8000; tick(40);
    bus.threshold_value = 50; bus.hysteresis = 10; bus.thr_load = 1'b1; tick(1);
    bus.thr_load = 1'b0; bus.threshold_value = -5; tick(5);
    check("load_idle", bus.fsm_state, 0);

    // first trigger: 4 cycles after the step
    bus.x = 6000; tick(3);
    check("trig_early", bus.trigger_output, 0);
    tick(1);
    check("trig_pulse", bus.trigger_output, 1);
    check("trig_count1", bus.trig_count, 1);
    check("trig_busy", bus.busy, 1);
    check("trig_state", bus.fsm_state, 1);
    bus.x = 7955; tick(1);
    check("trig_single", bus.trigger_output, 0);
    check("hold_state0", bus.fsm_state, 2);
    tick(7);
    check("hold_state_end", bus.fsm_state, 2);
    check("hold_busy", bus.busy, 1);
    tick(1);
    check("rearm_state", bus.fsm_state, 3);
    check("one_pulse", pulse_cnt, 1);

    // s=45 sits inside the hysteresis band; s=39 re-arms
    tick(60);
    check("band_state", bus.fsm_state, 3);
    check("band_count", bus.trig_count, 1);
    bus.x = 7961; tick(45);
    check("rearm_idle", bus.fsm_state, 0);
    check("rearm_busy", bus.busy, 0);
    bus.x = 7940; tick(60);
    check("second_count", bus.trig_count, 2);
    check("second_pulse", pulse_cnt, 2);
    check("second_rearm", bus.fsm_state, 3);

    // channel gating
    bus.x = 8000; tick(50);
    check("gate_pre_idle", bus.fsm_state, 0);
    bus.trigger_ch_enable = 1'b0;
    bus.x = 6000; tick(1);
    bus.x = 8000; tick(3);
    check("gate_state", bus.fsm_state, 1);
    check("gate_trig", bus.trigger_output, 0);
    check("gate_count", bus.trig_count, 3);
    tick(45);
    check("gate_pulse", pulse_cnt, 2);
    bus.trigger_ch_enable = 1'b1;

    // bypass
    bus.enable = 1'b0; bus.output_sel = 2'b01; tick(1);
    check("byp_state", bus.fsm_state, 0);
    bus.x = 123; tick(1);
    bus.x = -77; tick(1);
    bus.x = 6000; tick(1);
    check("byp_y0", bus.y, 123);
    tick(1);
    check("byp_y1", bus.y, -77);
    tick(1);
    check("byp_y2", bus.y, 6000);
    tick(10);
    check("byp_count", bus.trig_count, 3);
    check("byp_busy", bus.busy, 0);
    bus.x = 8000; bus.enable = 1'b1; tick(40);
    check("byp_resume_state", bus.fsm_state, 0);

    // clear alone, then saturation
    bus.count_clr = 1'b1; tick(1);
    bus.count_clr = 1'b0;
    check("clr_alone", bus.trig_count, 0);
    for (int i = 0; i < 20; i++) begin
      bus.x = 6000; tick(1);
      bus.x = 8000; tick(44);
    end
    check("sat_count", bus.trig_count, 15);
    check("sat_pulse", pulse_cnt, 22);
    check("sat_state", bus.fsm_state, 0);

    // clear coincident with a TRIG cycle
    bus.x = 6000; tick(1);
    bus.x = 8000; tick(2);
    bus.count_clr = 1'b1; tick(1);
    bus.count_clr = 1'b0;
    check("clr_trig_count", bus.trig_count, 1);
    check("clr_trig_pulse", bus.trigger_output, 1);
    tick(45);
    check("clr_trig_after", bus.trig_count, 1);
    check("final_pulse", pulse_cnt, 23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
